// File: rtl/tx_sched_pkg.sv
// Shared constants for the Tx frame scheduler: modulation codes, FSM encoding, port indices.
package tx_sched_pkg;

  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  localparam logic PORT_BPSK = 1'b0;
  localparam logic PORT_QPSK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  function automatic logic [3:0] port_mode(input logic port);
    return (port == PORT_QPSK) ? MODE_QPSK : MODE_BPSK;
  endfunction

endpackage

// File: rtl/tx_sched_rr_arb.sv
// Two-way round-robin arbiter; MODE_CTRL masks which sources are eligible.
module tx_sched_rr_arb
  import tx_sched_pkg::*;
(
  input  logic [3:0] mode_ctrl,
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid,
  output logic       last_grant_nxt
);

  logic elig0;
  logic elig1;

  always_comb begin
    elig0 = req0 & ((mode_ctrl == MODE_BPSK) | (mode_ctrl == MODE_MIX));
    elig1 = req1 & ((mode_ctrl == MODE_QPSK) | (mode_ctrl == MODE_MIX));
    grant_valid = elig0 | elig1;
    // on a tie, the port that did not win last time goes first
    if (elig0 && elig1) begin
      grant = ~last_grant;
    end else begin
      grant = elig1;
    end
    last_grant_nxt = grant_valid ? grant : last_grant;
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Per-frame arbiter sharing the Tx modulator byte stream between BPSK and QPSK sources.
// Optional frame length limit with sticky truncation flag: define TX_SCHED_MAXLEN_EN.
//
// state | meaning
// IDLE  | sample MODE_CTRL, pick a source, decide whether a guard gap is needed
// GUARD | modulation changed: hold the stream idle for GAP_CYCLES cycles
// XFER  | combinational pass-through of the granted source until tlast
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter int GAP_CYCLES    = 8,
  parameter int MAX_FRAME_LEN = 256
)
(
  input  logic       clk_1M024,
  input  logic       rst_n_1M024,
  input  logic [3:0] MODE_CTRL,
  input  logic [7:0] s0_tdata,
  input  logic       s0_tvalid,
  input  logic       s0_tlast,
  output logic       s0_tready,
  input  logic [7:0] s1_tdata,
  input  logic       s1_tvalid,
  input  logic       s1_tlast,
  output logic       s1_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic [3:0] mode_sel,
  output logic       busy,
  output logic       err_trunc
);

  localparam int CNT_W = $clog2(MAX_FRAME_LEN);

  state_t           state, state_nxt;
  logic [3:0]       mode_sel_nxt;
  logic [7:0]       gap_cnt, gap_cnt_nxt;
  logic             grant_q, grant_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic             first_pending, first_pending_nxt;

  logic             arb_grant;
  logic             arb_valid;
  logic             arb_last_grant;
  logic [3:0]       req_mode;

  logic             xfer;
  logic [7:0]       src_data;
  logic             src_valid;
  logic             src_last;
  logic             hs;

  tx_sched_rr_arb u_arb (
    .mode_ctrl      (MODE_CTRL),
    .req0           (s0_tvalid),
    .req1           (s1_tvalid),
    .last_grant     (last_grant),
    .grant          (arb_grant),
    .grant_valid    (arb_valid),
    .last_grant_nxt (arb_last_grant)
  );

  assign req_mode  = port_mode(arb_grant);
  assign xfer      = (state == ST_XFER);
  assign src_data  = (grant_q == PORT_QPSK) ? s1_tdata  : s0_tdata;
  assign src_valid = (grant_q == PORT_QPSK) ? s1_tvalid : s0_tvalid;
  assign src_last  = (grant_q == PORT_QPSK) ? s1_tlast  : s0_tlast;

  assign m_tvalid  = xfer & src_valid;
  assign m_tdata   = xfer ? src_data : 8'h00;
  assign m_tuser   = first_pending & m_tvalid;
  assign s0_tready = xfer & (grant_q == PORT_BPSK) & m_tready;
  assign s1_tready = xfer & (grant_q == PORT_QPSK) & m_tready;
  assign busy      = (state != ST_IDLE);
  assign hs        = m_tvalid & m_tready;

`ifdef TX_SCHED_MAXLEN_EN
  logic at_limit;
  logic trunc;

  assign at_limit = (byte_cnt == CNT_W'(MAX_FRAME_LEN - 1));
  // a frame hitting the limit is closed here; the rest of it becomes a new frame
  assign m_tlast  = m_tvalid & (src_last | at_limit);
  assign trunc    = hs & at_limit & ~src_last;

  always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
    if (!rst_n_1M024) begin
      err_trunc <= 1'b0;
    end else if (trunc) begin
      err_trunc <= 1'b1;
    end
  end
`else
  assign m_tlast   = m_tvalid & src_last;
  assign err_trunc = 1'b0;
`endif

  always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
    if (!rst_n_1M024) begin
      state         <= ST_IDLE;
      mode_sel      <= MODE_BPSK;
      gap_cnt       <= 8'd0;
      grant_q       <= PORT_BPSK;
      last_grant    <= PORT_QPSK;
      byte_cnt      <= '0;
      first_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      mode_sel      <= mode_sel_nxt;
      gap_cnt       <= gap_cnt_nxt;
      grant_q       <= grant_nxt;
      last_grant    <= last_grant_nxt;
      byte_cnt      <= byte_cnt_nxt;
      first_pending <= first_pending_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    mode_sel_nxt      = mode_sel;
    gap_cnt_nxt       = gap_cnt;
    grant_nxt         = grant_q;
    last_grant_nxt    = last_grant;
    byte_cnt_nxt      = byte_cnt;
    first_pending_nxt = first_pending;

    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_nxt         = arb_grant;
          last_grant_nxt    = arb_last_grant;
          first_pending_nxt = 1'b1;
          if (req_mode != mode_sel) begin
            mode_sel_nxt = req_mode;
            gap_cnt_nxt  = 8'(GAP_CYCLES - 1);
            state_nxt    = ST_GUARD;
          end else begin
            state_nxt = ST_XFER;
          end
        end
      end
      ST_GUARD: begin
        if (gap_cnt == 8'd0) begin
          state_nxt = ST_XFER;
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end
      ST_XFER: begin
        if (hs) begin
          first_pending_nxt = 1'b0;
          if (m_tlast) begin
            byte_cnt_nxt = '0;
            state_nxt    = ST_IDLE;
          end else begin
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: expected bytes and frame gaps are queued as stimulus
// is issued and checked as the modulator side accepts bytes.
module tb_tx_frame_scheduler;

  localparam int GAP = 8;
`ifdef TX_SCHED_MAXLEN_EN
  localparam int MAXLEN = 4;
`else
  localparam int MAXLEN = 256;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] mode_ctrl;
  logic [7:0] s0_tdata, s1_tdata, m_tdata;
  logic       s0_tvalid, s0_tlast, s0_tready;
  logic       s1_tvalid, s1_tlast, s1_tready;
  logic       m_tvalid, m_tready, m_tlast, m_tuser;
  logic [3:0] mode_sel;
  logic       busy, err_trunc;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_cyc = 0;
  int s1_rdy_hits = 0;

  logic [13:0] sb[$];
  int          gap_q[$];

  always #5 clk = ~clk;

  tx_frame_scheduler #(.GAP_CYCLES(GAP), .MAX_FRAME_LEN(MAXLEN)) dut (
    .clk_1M024(clk), .rst_n_1M024(rst_n), .MODE_CTRL(mode_ctrl),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .mode_sel(mode_sel), .busy(busy), .err_trunc(err_trunc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // entry layout: {data, last, user, mode}
  task automatic push_frame(input bit port, input logic [7:0] base, input int len,
                            input bit with_last, input int gap);
    for (int i = 0; i < len; i++) begin
      sb.push_back({8'(base + i), with_last && (i == len - 1), i == 0,
                    port ? 4'b0010 : 4'b0001});
    end
    gap_q.push_back(gap);
  endtask

  task automatic drive_bytes(input bit port, input logic [7:0] base, input int len,
                             input bit with_last);
    int w;
    bit hs;
    for (int i = 0; i < len; i++) begin
      if (port) begin
        s1_tdata = 8'(base + i); s1_tlast = with_last && (i == len - 1); s1_tvalid = 1'b1;
      end else begin
        s0_tdata = 8'(base + i); s0_tlast = with_last && (i == len - 1); s0_tvalid = 1'b1;
      end
      w = 0;
      do begin
        @(negedge clk);
        hs = port ? s1_tready : s0_tready;
        @(posedge clk);
        #1;
        w++;
      end while (!hs && w < 200);
      if (!hs) begin
        check("drive_timeout", 32'(hs), 32'd1);
        break;
      end
    end
    if (port) begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
    else      begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
  endtask

  task automatic expect_lead(input int exp_n);
    int n = 0;
    @(negedge clk);
    while (!m_tvalid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("lead_idle_cycles", 32'(n), 32'(exp_n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {m_tvalid, m_tlast, m_tuser, s0_tready, s1_tready, busy, err_trunc, m_tdata, mode_sel},
          {7'b0, 8'h00, 4'b0001});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [13:0] e;
    int g;
    cyc++;
    if (s1_tready) s1_rdy_hits++;
    if (rst_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("byte", {18'd0, m_tdata, m_tlast, m_tuser, mode_sel}, {18'd0, e});
      end
      if (m_tuser && gap_q.size() > 0) begin
        g = gap_q.pop_front();
        if (g >= 0) check("frame_gap", 32'(cyc - last_cyc), 32'(g));
      end
      if (m_tlast) last_cyc = cyc;
    end
  end

  initial begin
    int hits0;
    bit done;
    rst_n = 1'b0; mode_ctrl = 4'b0001; m_tready = 1'b1;
    s0_tdata = 8'h00; s0_tvalid = 1'b0; s0_tlast = 1'b0;
    s1_tdata = 8'h00; s1_tvalid = 1'b0; s1_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // BPSK-only, s1 requesting but ineligible
    mode_ctrl = 4'b0001;
    s1_tvalid = 1'b1; s1_tdata = 8'h55;
    hits0 = s1_rdy_hits;
    push_frame(0, 8'hA0, 4, 1, -1);
    fork
      drive_bytes(0, 8'hA0, 4, 1);
      expect_lead(1);
    join
    check("bpsk_s1_tready_hits", 32'(s1_rdy_hits - hits0), 32'd0);
    s1_tvalid = 1'b0;

    // illegal mode grants nothing
    mode_ctrl = 4'b0011;
    s0_tvalid = 1'b1; s0_tdata = 8'h77;
    repeat (3) @(negedge clk);
    check("illegal_mode_idle", {29'd0, busy, m_tvalid, s0_tready}, 32'd0);
    @(posedge clk); #1;
    s0_tvalid = 1'b0;

    // MIX: fresh reset so port 0 wins the first tie and mode starts BPSK
    do_reset();
    mode_ctrl = 4'b0100;
    push_frame(0, 8'hB0, 2, 1, -1);
    push_frame(1, 8'hC0, 2, 1, GAP + 2);
    push_frame(0, 8'hB2, 2, 1, GAP + 2);
    push_frame(1, 8'hC2, 2, 1, GAP + 2);
    fork
      begin drive_bytes(0, 8'hB0, 2, 1); drive_bytes(0, 8'hB2, 2, 1); end
      begin drive_bytes(1, 8'hC0, 2, 1); drive_bytes(1, 8'hC2, 2, 1); end
    join
    @(negedge clk);
    check("mix_final_mode", 32'(mode_sel), 32'h2);

    // QPSK-only: s0 alone is ignored, then s1 gets a guard gap
    do_reset();
    mode_ctrl = 4'b0010;
    s0_tvalid = 1'b1; s0_tdata = 8'hEE;
    repeat (2) @(negedge clk);
    check("qpsk_s0_blocked", {30'd0, s0_tready, m_tvalid}, 32'd0);
    @(negedge clk);
    check("qpsk_mode_before", 32'(mode_sel), 32'h1);
    @(posedge clk); #1;
    push_frame(1, 8'hD0, 3, 1, -1);
    fork
      drive_bytes(1, 8'hD0, 3, 1);
      expect_lead(GAP + 1);
    join
    s0_tvalid = 1'b0;

    // m_tready toggling 1010 during a 6-byte BPSK frame
    mode_ctrl = 4'b0001;
    push_frame(0, 8'hE0, 6, 1, -1);
    done = 1'b0;
    fork
      begin drive_bytes(0, 8'hE0, 6, 1); done = 1'b1; end
      begin
        for (int k = 0; k < 100 && !done; k++) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    @(negedge clk);
    check("byte_cnt_after_tlast", 32'(dut.byte_cnt), 32'd0);
    check("sb_drained_toggle", 32'(sb.size()), 32'd0);

    // reset in the middle of a 5-byte frame, after byte 2
    @(posedge clk); #1;
    push_frame(0, 8'hF0, 2, 0, -1);
    drive_bytes(0, 8'hF0, 2, 0);
    s0_tvalid = 1'b1; s0_tdata = 8'hF2;
    #1;
    check("midframe_valid", 32'(m_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    s0_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_frame(0, 8'h40, 3, 1, -1);
    drive_bytes(0, 8'h40, 3, 1);

`ifdef TX_SCHED_MAXLEN_EN
    // 6-byte frame against a 4-byte limit splits into 4 + 2
    sb.push_back({8'h60, 1'b0, 1'b1, 4'b0001});
    sb.push_back({8'h61, 1'b0, 1'b0, 4'b0001});
    sb.push_back({8'h62, 1'b0, 1'b0, 4'b0001});
    sb.push_back({8'h63, 1'b1, 1'b0, 4'b0001});
    gap_q.push_back(-1);
    sb.push_back({8'h64, 1'b0, 1'b1, 4'b0001});
    sb.push_back({8'h65, 1'b1, 1'b0, 4'b0001});
    gap_q.push_back(2);
    drive_bytes(0, 8'h60, 6, 1);
    @(negedge clk);
    check("err_trunc_set", 32'(err_trunc), 32'd1);
`else
    @(negedge clk);
    check("err_trunc_tied", 32'(err_trunc), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained_final", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
Per-frame arbiter sharing the single Tx modulator byte stream between a BPSK frame source (port 0) and a QPSK frame source (port 1).
- Sits in the 1.024 MHz symbol domain, ahead of Tx's data_tdata/tvalid/tlast/tuser input.
- Selects the source by MODE_CTRL: BPSK-only, QPSK-only, or MIX (round-robin per frame).
- Drives the modulator mode and inserts a guard gap whenever the modulation changes between frames.

Parameters:
GAP_CYCLES, 8, idle clk cycles inserted before a frame whose mode differs from the previous frame's mode (range 1..255)
MAX_FRAME_LEN, 256, maximum bytes per frame, used only with TX_SCHED_MAXLEN_EN (range 2..65535)

Ports:
clk_1M024  in  1  symbol-rate clock
rst_n_1M024  in  1  asynchronous active-low reset
MODE_CTRL  in  4  0001 BPSK-only, 0010 QPSK-only, 0100 MIX; any other value means no grants
s0_tdata  in  8  BPSK source byte
s0_tvalid  in  1  BPSK source valid
s0_tlast  in  1  BPSK source last byte of frame
s0_tready  out  1  BPSK source ready
s1_tdata  in  8  QPSK source byte
s1_tvalid  in  1  QPSK source valid
s1_tlast  in  1  QPSK source last byte of frame
s1_tready  out  1  QPSK source ready
m_tdata  out  8  byte to modulator
m_tvalid  out  1  byte valid
m_tready  in  1  modulator ready
m_tlast  out  1  last byte of frame
m_tuser  out  1  high on the first byte of each frame
mode_sel  out  4  active modulation: 0001 or 0010
busy  out  1  high in GUARD or XFER
err_trunc  out  1  sticky flag: frame truncated (TX_SCHED_MAXLEN_EN only; otherwise tied 0)

Behaviour:
Reset values (asynchronous):
- state=IDLE, mode_sel=0001, last_grant=1 (so port 0 wins the first MIX tie), byte_cnt=0, gap_cnt=0, err_trunc=0.
- All m_* outputs 0; s0_tready and s1_tready 0.

IDLE:
- MODE_CTRL is sampled only in IDLE.
- Eligible ports: BPSK-only means port 0 if s0_tvalid; QPSK-only means port 1 if s1_tvalid; MIX means any valid port.
- MIX with both valid: grant the port not equal to last_grant.
- Illegal MODE_CTRL: stay in IDLE, grant nothing.
- On a grant: latch grant and set last_grant=grant.
- req_mode = grant ? 0010 : 0001.
- If req_mode != mode_sel: set mode_sel=req_mode and gap_cnt=GAP_CYCLES-1, go to GUARD. Otherwise go to XFER.
- first_pending is set on leaving IDLE.

GUARD:
- m_tvalid=0 and both treadys 0.
- Decrement gap_cnt each cycle; at 0, go to XFER.
- This gives exactly GAP_CYCLES idle cycles after the IDLE decision cycle.

XFER:
- Zero-latency combinational pass-through of the granted port: m_tdata, m_tvalid and m_tlast come from that port, and its tready equals m_tready.
- The ungranted port's tready is 0.
- m_tuser = first_pending & m_tvalid. first_pending clears on the first handshake (m_tvalid & m_tready).
- Each handshake increments byte_cnt.
- A handshake with m_tlast=1 clears byte_cnt and returns to IDLE. The next grant is earliest on the following cycle, so there is at least 1 idle cycle between frames.
- The source dropping tvalid mid-frame leaves the grant held (no timeout); m_tvalid follows it.
- MODE_CTRL changes mid-frame take effect at the next IDLE.

Back-to-back frames: frames of the same mode have a 1-cycle gap; a mode switch adds GAP_CYCLES more.

Reset asserted mid-frame: immediate return to reset values. The partial frame is not terminated with tlast; upstream sources are reset by the same reset.

Optional Feature:
Macro TX_SCHED_MAXLEN_EN.
- Defined: on the handshake where byte_cnt == MAX_FRAME_LEN-1 and the source tlast=0:
  - m_tlast is forced to 1;
  - err_trunc is set (sticky until reset);
  - the state returns to IDLE.
  The source's remaining bytes are presented as a new frame, with m_tuser asserted on its first byte.
- Undefined: no length limit, byte_cnt is not compared, err_trunc is tied 0.

Decomposition:
- Shared package tx_sched_pkg: MODE_BPSK/MODE_QPSK/MODE_MIX 4-bit constants (shared with Tx/Rx), state encoding (IDLE, GUARD, XFER) and port index constants.
- One natural sub-module, tx_sched_rr_arb: 2-way round-robin arbiter with mode mask, producing grant, grant_valid and updated last_grant. The FSM and pass-through mux stay in the top module.

Test Plan:
- BPSK-only, 4-byte s0 frame (A0..A3), m_tready=1:
  - no gap, since mode_sel is already 0001;
  - m_tuser high with A0 only, m_tlast with A3;
  - s1_tready stays 0 throughout.
- MIX, both ports hold 2-byte frames continuously:
  - grants alternate 0,1,0,1;
  - each mode switch shows exactly 8 cycles with m_tvalid=0 plus the IDLE cycle;
  - mode_sel toggles 0001/0010 before each frame's first byte.
- QPSK-only with s0_tvalid=1 and s1_tvalid=0: no grant and s0_tready=0. Then s1 asserts: 8-cycle guard, then mode_sel=0010 and transfer.
- m_tready toggled 1010 during a 6-byte frame: bytes arrive in order with no loss or duplication; m_tuser fires once; byte_cnt=0 after tlast.
- Reset pulse after byte 2 of a 5-byte frame: all outputs return to reset values in the same cycle; the next frame starts with m_tuser=1.
- With TX_SCHED_MAXLEN_EN and MAX_FRAME_LEN=4, a 6-byte frame:
  - m_tlast is forced on byte 4 and err_trunc=1;
  - bytes 5-6 are output as a new frame with m_tuser on byte 5.
